lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store initiator between the pipeline MEM stage and the word-wide, big-endian data memory. It turns byte, halfword and word loads/stores into memory accesses on a word-aligned address. Sub-word stores become a read-modify-write, because the memory only writes whole words. It returns sign- or zero-extended load data and a store acknowledge on a one-cycle response strobe, and reports misaligned or out-of-range accesses.

Parameters:
MEM_BYTES, 4096, data memory size in bytes; an address >= MEM_BYTES is out of range.
WORD_WIDTH, 32, data and address width (fixed at 32).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present from MEM stage
req_ready  output  1  high only in IDLE; request accepted on clk edge when req_valid&req_ready
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  input  1  sign-extend load result (ignored for word loads and stores)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle completion strobe
rsp_err  output  1  valid with rsp_valid; 1 = misaligned, illegal size or out of range
rsp_rdata  output  32  load result, valid with rsp_valid; 0 for stores and errors
data_wr  output  1  memory write enable, registered
data_addr  output  32  word-aligned memory address, registered
data_in  output  32  memory write data, registered
data_out  input  32  memory read data; combinational from data_addr

Behaviour:
- Reset (async, immediate): state IDLE. data_wr, data_addr, data_in, rsp_valid, rsp_err and rsp_rdata are 0. req_ready is 1 once out of reset.
- Reset mid-operation aborts the access. data_wr drops immediately, no write occurs and no response is issued.
- Byte order is big-endian: byte offset k of a word maps to bits [31-8k:24-8k]. Halfword offset 0 maps to [31:16] and offset 2 maps to [15:0].
- Error check at accept:
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - size=11 is an error.
  - addr > MEM_BYTES-4 is an error.
  - On error, stay in IDLE with no memory access. The next cycle gives rsp_valid=1, rsp_err=1, rsp_rdata=0.
- FSM states: IDLE, READ, RMW, WRITE.
  - IDLE, on accept (no error): latch size/signed/offset/wdata and set data_addr = {addr[31:2],2'b00}.
    - Load -> READ.
    - Word store -> WRITE, with data_in = wdata and data_wr = 1 registered.
    - Sub-word store -> RMW.
  - READ: extract the lane from data_out and extend it. Register rsp_rdata and rsp_valid=1, then go to IDLE.
    - Load latency: accept at edge N, response high in cycle N+2.
  - RMW: merge the shifted wdata lane into data_out, keeping the other bytes. Register the result into data_in, set data_wr=1, go to WRITE.
  - WRITE: data_wr=1 for exactly this cycle, and the memory writes on the closing edge. Then data_wr=0, rsp_valid=1, rsp_rdata=0, go to IDLE.
    - Word store acknowledges in N+2; sub-word store in N+3.
- Pipelining and hold rules:
  - rsp_valid coincides with IDLE, so a new request can be accepted in the same cycle as a response (back-to-back).
  - A load following a store to the same word sees the new data.
  - req_* inputs are sampled only at accept; they may change afterwards.
  - rsp_rdata holds its value until the next response.
- Extension: a byte load uses bit 7 of the lane as the sign if req_signed, otherwise zero-fills. Halfwords use bit 15 the same way.

Decomposition:
- Shared package holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - FSM state encoding
  - WORD_WIDTH
- One natural sub-module, lsu_lane_align (combinational). It does lane extraction with sign/zero extension for loads, and the write-lane merge for stores, from size, offset, signed, word and wdata.

Test Plan:
1. Preload 0x10=0x11223344. lb 0x13 -> rsp_rdata=0x00000044, rsp_valid in cycle N+2, data_wr never high.
2. Preload 0x14=0x80FF7F01. lb signed 0x15 -> 0xFFFFFFFF. lbu 0x15 -> 0x000000FF. lh signed 0x14 -> 0xFFFF80FF. lhu 0x16 -> 0x00007F01.
3. sh 0x12 with wdata 0x0000ABCD onto 0x11223344 -> data_in=0x1122ABCD, data_wr high exactly one cycle (N+2), ack N+3. A following lw 0x10 returns 0x1122ABCD.
4. Error cases, each giving rsp_err=1 the next cycle with no memory access:
   - lh 0x11
   - lw 0x12
   - size=11
   - lw 0x1000 with MEM_BYTES=4096
5. sb 0x20 is accepted, then rst asserted during RMW -> data_wr stays 0, word at 0x20 unchanged, no rsp_valid. After release, req_ready=1 and a sw 0x20 of 0xDEADBEEF completes in N+2.
6. Back-to-back: sw 0x30 of 0xCAFEF00D accepted in the same cycle as the prior response. The following lw 0x30 returns 0xCAFEF00D with no idle gap.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: size codes, FSM encoding and data width shared by the load/store unit
package lsu_mem_ctrl_pkg;
  localparam int WORD_WIDTH = 32;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_RMW   = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: MEM-stage request/response and data-memory port bundle
interface lsu_mem_ctrl_if;
  import lsu_mem_ctrl_pkg::*;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [WORD_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [WORD_WIDTH-1:0] rsp_rdata;
  logic                  data_wr;
  logic [WORD_WIDTH-1:0] data_addr;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] data_out;
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, data_out,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, data_wr, data_addr, data_in
  );
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, data_out,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, data_wr, data_addr, data_in
  );
endinterface

// File: rtl/lsu_mem_ctrl_lane_align.sv
// lsu_lane_align: big-endian lane extract/extend for loads and lane merge for stores
module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [1:0]            size,
  input  logic [1:0]            off,
  input  logic                  sgn,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic [WORD_WIDTH-1:0] merged
);
  logic [4:0]            sh;
  logic [7:0]            b;
  logic [15:0]           h;
  logic [WORD_WIDTH-1:0] mask;
  always_comb begin
    sh     = size == SZ_BYTE ? {~off, 3'b000} : size == SZ_HALF ? {~off[1], 4'b0000} : 5'd0;
    b      = word[sh +: 8];
    h      = off[1] ? word[15:0] : word[31:16];
    mask   = size == SZ_BYTE ? 32'h0000_00ff << sh : size == SZ_HALF ? 32'h0000_ffff << sh : '1;
    rdata  = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} : size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
    merged = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator; sub-word stores go through read-modify-write
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = 4096
)(
  input logic          clk,
  input logic          rst,
  lsu_mem_ctrl_if.slave bus
);
  logic [1:0]            state;
  logic [1:0]            size_q;
  logic [1:0]            off_q;
  logic                  sgn_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] rdata;
  logic [WORD_WIDTH-1:0] merged;
  logic                  err;
  assign bus.req_ready = state == S_IDLE;
  assign err = bus.req_size == 2'b11
             | (bus.req_size == SZ_HALF && bus.req_addr[0])
             | (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
             | bus.req_addr > WORD_WIDTH'(MEM_BYTES - 4);
  lsu_lane_align u_align (
    .size   (size_q),
    .off    (off_q),
    .sgn    (sgn_q),
    .word   (bus.data_out),
    .wdata  (wdata_q),
    .rdata  (rdata),
    .merged (merged)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      size_q        <= '0;
      off_q         <= '0;
      sgn_q         <= 1'b0;
      wdata_q       <= '0;
      bus.data_wr   <= 1'b0;
      bus.data_addr <= '0;
      bus.data_in   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.data_wr   <= 1'b0;
      case (state)
        S_IDLE: if (bus.req_valid) begin
          if (err) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            size_q        <= bus.req_size;
            off_q         <= bus.req_addr[1:0];
            sgn_q         <= bus.req_signed;
            wdata_q       <= bus.req_wdata;
            bus.data_addr <= {bus.req_addr[WORD_WIDTH-1:2], 2'b00};
            if (!bus.req_we) state <= S_READ;
            else if (bus.req_size == SZ_WORD) begin
              bus.data_in <= bus.req_wdata;
              bus.data_wr <= 1'b1;
              state       <= S_WRITE;
            end else state <= S_RMW;
          end
        end
        S_READ: begin
          bus.rsp_rdata <= rdata;
          bus.rsp_valid <= 1'b1;
          state         <= S_IDLE;
        end
        S_RMW: begin
          bus.data_in <= merged;
          bus.data_wr <= 1'b1;
          state       <= S_WRITE;
        end
        default: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= '0;
          state         <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks of the load/store unit against a word memory model
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mem [0:1023];
  lsu_mem_ctrl_if bus ();
  lsu_mem_ctrl #(.MEM_BYTES(4096)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.data_out = mem[bus.data_addr[11:2]];
  always @(posedge clk) if (bus.data_wr) mem[bus.data_addr[11:2]] <= bus.data_in;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  int lat, wr_n, wr_lat;
  logic [31:0] rd, din;
  logic er;
  // drives at the current negedge, so consecutive calls are back-to-back with the prior response
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    lat = 0; wr_n = 0; wr_lat = 0; rd = 'x; er = 1'bx; din = 'x;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h5A5A_5A5A; bus.req_size = 2'b11;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.data_wr) begin wr_n++; wr_lat = c; din = bus.data_in; end
      if (bus.rsp_valid) begin lat = c; rd = bus.rsp_rdata; er = bus.rsp_err; break; end
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h1122_3344;
    mem[5] = 32'h80FF_7F01;
    mem[8] = 32'h5566_7788;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    #1;
    check("rst data_wr", {31'b0, bus.data_wr}, 32'h0);
    check("rst data_addr", bus.data_addr, 32'h0);
    check("rst data_in", bus.data_in, 32'h0);
    check("rst rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("rst rsp_err", {31'b0, bus.rsp_err}, 32'h0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready after rst", {31'b0, bus.req_ready}, 32'h1);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 0);
    check("lb 0x13 data", rd, 32'h0000_0044);
    check("lb 0x13 lat", lat, 2);
    check("lb 0x13 err", {31'b0, er}, 0);
    check("lb 0x13 no wr", wr_n, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h15, 0);
    check("lb s 0x15", rd, 32'hFFFF_FFFF);
    do_req(1'b0, 2'b00, 1'b0, 32'h15, 0);
    check("lbu 0x15", rd, 32'h0000_00FF);
    do_req(1'b0, 2'b01, 1'b1, 32'h14, 0);
    check("lh s 0x14", rd, 32'hFFFF_80FF);
    do_req(1'b0, 2'b01, 1'b0, 32'h16, 0);
    check("lhu 0x16", rd, 32'h0000_7F01);
    do_req(1'b0, 2'b01, 1'b1, 32'h16, 0);
    check("lh s 0x16", rd, 32'h0000_7F01);
    do_req(1'b0, 2'b00, 1'b1, 32'h14, 0);
    check("lb s 0x14", rd, 32'hFFFF_FF80);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD);
    check("sh din", din, 32'h1122_ABCD);
    check("sh wr count", wr_n, 1);
    check("sh wr cycle", wr_lat, 2);
    check("sh ack lat", lat, 3);
    check("sh ack rdata", rd, 32'h0);
    check("sh ack err", {31'b0, er}, 0);
    check("sh mem", mem[4], 32'h1122_ABCD);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 0);
    check("lw after sh", rd, 32'h1122_ABCD);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF99);
    check("sb 0x11 din", din, 32'h1199_ABCD);
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 0);
    check("lh 0x11 err", {31'b0, er}, 1);
    check("lh 0x11 lat", lat, 1);
    check("lh 0x11 rdata", rd, 0);
    check("lh 0x11 no wr", wr_n, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 0);
    check("lw 0x12 err", {31'b0, er}, 1);
    check("lw 0x12 lat", lat, 1);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 0);
    check("size11 err", {31'b0, er}, 1);
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h1);
    check("size11 st err", {31'b0, er}, 1);
    check("size11 st no wr", wr_n, 0);
    check("size11 st mem", mem[4], 32'h1199_ABCD);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 0);
    check("lw 0x1000 err", {31'b0, er}, 1);
    check("lw 0x1000 lat", lat, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFC, 0);
    check("lw 0xFFC ok", {31'b0, er}, 0);
    check("lw 0xFFC lat", lat, 2);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h0000_0011;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort data_wr", {31'b0, bus.data_wr}, 0);
    wr_n = 0; lat = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.data_wr) wr_n++;
      if (bus.rsp_valid) lat++;
    end
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (bus.data_wr) wr_n++;
      if (bus.rsp_valid) lat++;
    end
    check("abort no wr", wr_n, 0);
    check("abort no rsp", lat, 0);
    check("abort mem", mem[8], 32'h5566_7788);
    check("abort ready", {31'b0, bus.req_ready}, 1);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    check("sw 0x20 lat", lat, 2);
    check("sw 0x20 wr cycle", wr_lat, 1);
    check("sw 0x20 mem", mem[8], 32'hDEAD_BEEF);
    check("b2b rsp_valid", {31'b0, bus.rsp_valid}, 1);
    check("b2b ready", {31'b0, bus.req_ready}, 1);
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D);
    check("sw 0x30 lat", lat, 2);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 0);
    check("lw 0x30", rd, 32'hCAFE_F00D);
    check("lw 0x30 lat", lat, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h23, 0);
    check("lbu 0x23", rd, 32'h0000_00EF);
    @(negedge clk);
    check("rdata hold", bus.rsp_rdata, 32'h0000_00EF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
